// File: rtl/step_cnt_gen.sv
// Step counter: adds step_r per accepted advance, modulo L (or saturating at L-1 with STEP_CNT_GEN_SAT_EN).
// Latency 1: dout/dout_vld/wrap/cfg_err are registered one cycle after the triggering input.
// No backpressure: every din_vld cycle is accepted unless cfg_load is high in the same cycle.
module step_cnt_gen #(
  parameter int DATA_W    = 8,
  parameter int STEP_W    = 8,
  parameter int STEP_DEF  = 2,
  parameter int LIMIT_DEF = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [DATA_W-1:0] cfg_limit,
  input  logic              din_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              wrap,
  output logic              cfg_err
);

  localparam int LIM_W = DATA_W + 1;
  localparam int SUM_W = DATA_W + 2;
  localparam int CMP_W = ((STEP_W > LIM_W) ? STEP_W : LIM_W) + 1;

  if (!(STEP_DEF >= 0 && STEP_DEF < LIMIT_DEF && 64'(LIMIT_DEF) <= (64'd1 << DATA_W))) begin : g_param_chk
    $error("step_cnt_gen: parameters must satisfy STEP_DEF < LIMIT_DEF <= 2**DATA_W");
  end

  logic [STEP_W-1:0] step_q, step_d;
  logic [LIM_W-1:0]  limit_q, limit_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              wrap_q, wrap_d;
  logic              cfg_err_q, cfg_err_d;

  logic [LIM_W-1:0]  lim_new;
  logic              cfg_ok;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  lim_ext;
`ifdef STEP_CNT_GEN_SAT_EN
  logic [DATA_W-1:0] top;
`endif

  always_comb begin
    step_d     = step_q;
    limit_d    = limit_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    wrap_d     = 1'b0;
    cfg_err_d  = 1'b0;

    // A zero cfg_limit stands for the full 2^DATA_W range.
    lim_new = {1'b0, cfg_limit};
    if (cfg_limit == '0) begin
      lim_new = {1'b1, {DATA_W{1'b0}}};
    end
    cfg_ok  = CMP_W'(cfg_step) < CMP_W'(lim_new);
    sum     = SUM_W'(cnt_q) + SUM_W'(step_q);
    lim_ext = SUM_W'(limit_q);
`ifdef STEP_CNT_GEN_SAT_EN
    top     = limit_q[DATA_W-1:0] - DATA_W'(1);
`endif

    if (cfg_load) begin
      if (cfg_ok) begin
        step_d  = cfg_step;
        limit_d = lim_new;
        cnt_d   = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (din_vld) begin
      dout_d     = cnt_q;
      dout_vld_d = 1'b1;
`ifdef STEP_CNT_GEN_SAT_EN
      if (sum >= lim_ext) begin
        cnt_d = top;
      end else begin
        cnt_d = DATA_W'(sum);
      end
      // cnt_q is always below L, so cnt_q != top means the count arrives at L-1 from below.
      wrap_d = (cnt_q != top) && (cnt_d == top);
`else
      if (sum >= lim_ext) begin
        cnt_d  = DATA_W'(sum - lim_ext);
        wrap_d = 1'b1;
      end else begin
        cnt_d = DATA_W'(sum);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q     <= STEP_W'(STEP_DEF);
      limit_q    <= LIM_W'(LIMIT_DEF);
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      step_q     <= step_d;
      limit_q    <= limit_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      wrap_q     <= wrap_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign wrap     = wrap_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_step_cnt_gen.sv
// Bench for step_cnt_gen: directed scenarios plus randomized traffic against an integer reference model.
// Define STEP_CNT_GEN_SAT_EN for both bench and RTL to exercise the saturating build.
module tb_step_cnt_gen;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_step;
  logic [7:0] cfg_limit;
  logic       din_vld;
  logic [7:0] dout;
  logic       dout_vld;
  logic       wrap;
  logic       cfg_err;

  step_cnt_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_step  (cfg_step),
    .cfg_limit (cfg_limit),
    .din_vld   (din_vld),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .wrap      (wrap),
    .cfg_err   (cfg_err)
  );

  int cmp_n = 0;
  int err_n = 0;

  // Reference model state: plain integers for step, modulus, count and last sample.
  int m_step, m_lim, m_cnt, m_dout;
  logic        e_vld, e_wrap, e_err;
  logic [10:0] exp_o;
  logic [10:0] obs;
  assign obs = {dout, dout_vld, wrap, cfg_err};

`ifdef STEP_CNT_GEN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input bit rs, input bit ld, input int st, input int lm, input bit v);
    int s, nc, lnew;
    rst_n     = !rs;
    cfg_load  = ld;
    cfg_step  = st[7:0];
    cfg_limit = lm[7:0];
    din_vld   = v;
    @(posedge clk);
    #1;
    e_vld = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
    if (rs) begin
      m_cnt = 0; m_dout = 0; m_step = 2; m_lim = 200;
    end else if (ld) begin
      lnew = (lm[7:0] == 0) ? 256 : int'(lm[7:0]);
      if (int'(st[7:0]) < lnew) begin
        m_step = int'(st[7:0]); m_lim = lnew; m_cnt = 0;
      end else begin
        e_err = 1'b1;
      end
    end else if (v) begin
      e_vld  = 1'b1;
      m_dout = m_cnt;
      s      = m_cnt + m_step;
      if (SAT) begin
        nc     = (s >= m_lim) ? m_lim - 1 : s;
        e_wrap = (m_cnt < m_lim - 1) && (nc == m_lim - 1);
      end else begin
        nc     = (s >= m_lim) ? s - m_lim : s;
        e_wrap = (s >= m_lim);
      end
      m_cnt = nc;
    end
    exp_o = {m_dout[7:0], e_vld, e_wrap, e_err};
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 5, 9, 1);
      cmp_n++;
      if (obs !== 11'h0) begin
        err_n++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs, 11'h0);
      end
    end
    cyc(0, 0, 0, 0, 0);
    cmp_n++;
    if (obs !== 11'h0) begin
      err_n++;
      $display("FAIL reset_release got=%h want=%h", obs, 11'h0);
    end
  endtask

  task automatic test_default_run();
    for (int i = 0; i < 101; i++) begin
      cyc(0, 0, $urandom % 256, $urandom % 256, 1);
      cmp_n++;
      if (obs !== exp_o) begin
        err_n++;
        $display("FAIL default_run[%0d] got=%h want=%h", i, obs, exp_o);
      end
`ifndef STEP_CNT_GEN_SAT_EN
      cmp_n++;
      if (dout !== 8'((2 * i) % 200)) begin
        err_n++;
        $display("FAIL default_run_dout[%0d] got=%0d want=%0d", i, dout, (2 * i) % 200);
      end
`endif
    end
  endtask

  task automatic test_cfg_load();
    logic [7:0] seq [5];
    seq = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2};
    cyc(0, 1, 3, 10, 0);
    cmp_n++;
    if (obs !== exp_o) begin
      err_n++;
      $display("FAIL cfg_load_hold got=%h want=%h", obs, exp_o);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      cmp_n++;
      if (obs !== exp_o) begin
        err_n++;
        $display("FAIL cfg_load_run[%0d] got=%h want=%h", i, obs, exp_o);
      end
`ifndef STEP_CNT_GEN_SAT_EN
      cmp_n++;
      if (dout !== seq[i]) begin
        err_n++;
        $display("FAIL cfg_load_dout[%0d] got=%0d want=%0d", i, dout, seq[i]);
      end
`endif
    end
  endtask

  task automatic test_cfg_err();
    cyc(0, 1, 2, 200, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 10, 10, 0);
    cmp_n++;
    if (cfg_err !== 1'b1 || obs !== exp_o) begin
      err_n++;
      $display("FAIL cfg_err_pulse got=%h want=%h", obs, exp_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      cmp_n++;
      if (obs !== exp_o || dout !== 8'(6 + 2 * i)) begin
        err_n++;
        $display("FAIL cfg_err_keep[%0d] got=%h want=%h dout_want=%0d", i, obs, exp_o, 6 + 2 * i);
      end
    end
  endtask

  task automatic test_full_range();
    cyc(0, 1, 255, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      cmp_n++;
      if (obs !== exp_o) begin
        err_n++;
        $display("FAIL full_range[%0d] got=%h want=%h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_collision();
    cyc(0, 1, 10, 200, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 7, 120, 1);
    cmp_n++;
    if (obs !== exp_o || dout_vld !== 1'b0 || wrap !== 1'b0) begin
      err_n++;
      $display("FAIL collision got=%h want=%h", obs, exp_o);
    end
    cyc(0, 0, 0, 0, 1);
    cmp_n++;
    if (obs !== exp_o || dout !== 8'd0) begin
      err_n++;
      $display("FAIL collision_restart got=%h want=%h", obs, exp_o);
    end
  endtask

  task automatic test_step_zero();
    cyc(0, 1, 0, 7, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      cmp_n++;
      if (obs !== exp_o || dout !== 8'd0 || wrap !== 1'b0) begin
        err_n++;
        $display("FAIL step_zero[%0d] got=%h want=%h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_mid_reset();
    cyc(0, 1, 9, 50, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 3, 30, 1);
    cmp_n++;
    if (obs !== 11'h0) begin
      err_n++;
      $display("FAIL mid_reset got=%h want=%h", obs, 11'h0);
    end
    cyc(0, 0, 0, 0, 1);
    cmp_n++;
    if (obs !== exp_o || dout !== 8'd0) begin
      err_n++;
      $display("FAIL mid_reset_resume got=%h want=%h", obs, exp_o);
    end
  endtask

`ifdef STEP_CNT_GEN_SAT_EN
  task automatic test_sat();
    logic [7:0] seq [7];
    int wraps;
    seq = '{8'd0, 8'd4, 8'd8, 8'd9, 8'd9, 8'd9, 8'd9};
    wraps = 0;
    cyc(0, 1, 4, 10, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 1);
      wraps += int'(wrap);
      cmp_n++;
      if (obs !== exp_o || dout !== seq[i]) begin
        err_n++;
        $display("FAIL sat_run[%0d] got=%h want=%h dout_want=%0d", i, obs, exp_o, seq[i]);
      end
    end
    cmp_n++;
    if (wraps != 1) begin
      err_n++;
      $display("FAIL sat_wrap_count got=%0d want=1", wraps);
    end
  endtask
`endif

  task automatic test_random();
    bit rs, ld, v;
    int st, lm;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom % 300) == 0;
      ld = ($urandom % 10) == 0;
      v  = ($urandom % 4) != 0;
      st = (($urandom % 3) == 0) ? int'($urandom % 256) : int'($urandom % 16);
      lm = (($urandom % 6) == 0) ? 0 : int'($urandom % 256);
      cyc(rs, ld, st, lm, v);
      cmp_n++;
      if (obs !== exp_o) begin
        err_n++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_o);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_step = '0; cfg_limit = '0; din_vld = 1'b0;
    m_step = 2; m_lim = 200; m_cnt = 0; m_dout = 0;
    test_reset();
    test_default_run();
    test_cfg_load();
    test_cfg_err();
    test_full_range();
    test_collision();
    test_step_zero();
    test_mid_reset();
`ifdef STEP_CNT_GEN_SAT_EN
    test_sat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
